// File: rtl/sirv_uartgpioport_mc_if.sv
// UART pin-port bundle: UART core side, shared configuration and pad controls for NCH channels.
// The master drives UART TX, configuration and pad inputs; the slave is the port block.
interface sirv_uartgpioport_mc_if #(
  parameter int NCH    = 1,
  parameter int FILT_W = 4
);
  logic [NCH-1:0]    io_uart_txd;
  logic [NCH-1:0]    io_uart_rxd;
  logic [FILT_W-1:0] io_cfg_filt_len;
  logic [NCH-1:0]    io_cfg_loopback;
  logic [NCH-1:0]    io_cfg_rx_pue;
  logic [NCH-1:0]    io_pins_rxd_i_ival;
  logic [NCH-1:0]    io_pins_rxd_o_oval;
  logic [NCH-1:0]    io_pins_rxd_o_oe;
  logic [NCH-1:0]    io_pins_rxd_o_ie;
  logic [NCH-1:0]    io_pins_rxd_o_pue;
  logic [NCH-1:0]    io_pins_rxd_o_ds;
  logic [NCH-1:0]    io_pins_txd_i_ival;
  logic [NCH-1:0]    io_pins_txd_o_oval;
  logic [NCH-1:0]    io_pins_txd_o_oe;
  logic [NCH-1:0]    io_pins_txd_o_ie;
  logic [NCH-1:0]    io_pins_txd_o_pue;
  logic [NCH-1:0]    io_pins_txd_o_ds;

  modport master (
    output io_uart_txd, io_cfg_filt_len, io_cfg_loopback, io_cfg_rx_pue,
    output io_pins_rxd_i_ival, io_pins_txd_i_ival,
    input  io_uart_rxd,
    input  io_pins_rxd_o_oval, io_pins_rxd_o_oe, io_pins_rxd_o_ie, io_pins_rxd_o_pue, io_pins_rxd_o_ds,
    input  io_pins_txd_o_oval, io_pins_txd_o_oe, io_pins_txd_o_ie, io_pins_txd_o_pue, io_pins_txd_o_ds
  );

  modport slave (
    input  io_uart_txd, io_cfg_filt_len, io_cfg_loopback, io_cfg_rx_pue,
    input  io_pins_rxd_i_ival, io_pins_txd_i_ival,
    output io_uart_rxd,
    output io_pins_rxd_o_oval, io_pins_rxd_o_oe, io_pins_rxd_o_ie, io_pins_rxd_o_pue, io_pins_rxd_o_ds,
    output io_pins_txd_o_oval, io_pins_txd_o_oe, io_pins_txd_o_ie, io_pins_txd_o_pue, io_pins_txd_o_ds
  );
endinterface

// File: rtl/sirv_uartgpioport_mc.sv
// Multi-channel UART pad port: per-channel loopback mux, 2-flop RX synchroniser and optional
// RX glitch filter (built only when SIRV_UARTGPIOPORT_MC_FILTER_EN is defined), plus pad controls.
module sirv_uartgpioport_mc #(
  parameter int NCH    = 1,
  parameter int FILT_W = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  sirv_uartgpioport_mc_if.slave io
);

  logic [NCH-1:0] src;
  logic [NCH-1:0] s1_d, s1_q;
  logic [NCH-1:0] s2_d, s2_q;

  always_comb begin
    src  = (io.io_cfg_loopback & io.io_uart_txd) | (~io.io_cfg_loopback & io.io_pins_rxd_i_ival);
    s1_d = src;
    s2_d = s1_q;
  end

  // Synchroniser stage boundary: reset parks the line at idle (1).
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

`ifdef SIRV_UARTGPIOPORT_MC_FILTER_EN
  localparam logic [FILT_W-1:0] CNT_ONE = {{(FILT_W-1){1'b0}}, 1'b1};

  logic [NCH-1:0]    f_d, f_q;
  logic [FILT_W-1:0] cnt_d [NCH];
  logic [FILT_W-1:0] cnt_q [NCH];

  // Counter saturates implicitly: once it reaches L the output flips and the count clears.
  always_comb begin
    f_d = f_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != f_q[i]) begin
        if (cnt_q[i] >= io.io_cfg_filt_len) f_d[i] = s2_q[i];
        else                                cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Filter stage boundary.
  always_ff @(posedge clock) begin
    if (reset) begin
      f_q <= '1;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      f_q <= f_d;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign io.io_uart_rxd = f_q;

  logic unused_ok;
  assign unused_ok = ^io.io_pins_txd_i_ival;
`else
  assign io.io_uart_rxd = s2_q;

  logic unused_ok;
  assign unused_ok = ^{io.io_pins_txd_i_ival, io.io_cfg_filt_len};
`endif

  // Pad controls are purely combinational and independent of reset.
  assign io.io_pins_rxd_o_oval = '0;
  assign io.io_pins_rxd_o_oe   = '0;
  assign io.io_pins_rxd_o_ie   = '1;
  assign io.io_pins_rxd_o_pue  = io.io_cfg_rx_pue;
  assign io.io_pins_rxd_o_ds   = '0;

  assign io.io_pins_txd_o_oval = io.io_uart_txd | io.io_cfg_loopback;
  assign io.io_pins_txd_o_oe   = '1;
  assign io.io_pins_txd_o_ie   = '0;
  assign io.io_pins_txd_o_pue  = '0;
  assign io.io_pins_txd_o_ds   = '0;

endmodule

// File: tb/tb_sirv_uartgpioport_mc.sv
// Self-checking bench for sirv_uartgpioport_mc (NCH=2): table of steady-state vectors plus
// hand-written reset, latency, glitch, loopback, live filter-length and mid-filter reset sequences.
module tb_sirv_uartgpioport_mc;

`ifdef SIRV_UARTGPIOPORT_MC_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  sirv_uartgpioport_mc_if #(.NCH(2), .FILT_W(4)) bus ();

  sirv_uartgpioport_mc #(.NCH(2), .FILT_W(4)) dut (
    .clock (clk),
    .reset (rst),
    .io    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0] loop;
    logic [1:0] txd;
    logic [1:0] pue;
    logic [1:0] pad;
    logic [1:0] e_oval;
    logic [1:0] e_pue;
    logic [1:0] e_rxd;
  } vec_t;

  vec_t vt [6];

  function automatic int exp_lat(input int l);
    return FILT ? l + 3 : 2;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Counts edges until rxd[ch] reaches tgt; -1 if it never does within the budget.
  task automatic meas(input int ch, input logic tgt, output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.io_uart_rxd[ch] == tgt) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic settle(input logic [3:0] l);
    bus.io_cfg_filt_len    = l;
    bus.io_cfg_loopback    = 2'b00;
    bus.io_uart_txd        = 2'b11;
    bus.io_pins_rxd_i_ival = 2'b11;
    step(20);
  endtask

  function automatic logic [15:0] const_pads();
    return {bus.io_pins_rxd_o_oval, bus.io_pins_rxd_o_oe, bus.io_pins_rxd_o_ie, bus.io_pins_rxd_o_ds,
            bus.io_pins_txd_o_oe, bus.io_pins_txd_o_ie, bus.io_pins_txd_o_pue, bus.io_pins_txd_o_ds};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  lat;
    bit  seen;
    int  glen [3];

    checks   = 0;
    failures = 0;

    //          loop   txd    pue    pad    e_oval e_pue  e_rxd
    vt[0] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    vt[1] = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10};
    vt[2] = '{2'b10, 2'b00, 2'b10, 2'b11, 2'b10, 2'b10, 2'b01};
    vt[3] = '{2'b11, 2'b01, 2'b11, 2'b00, 2'b11, 2'b11, 2'b01};
    vt[4] = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00};
    vt[5] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01, 2'b11};

    // Reset: pads low, two reset cycles, then line must be idle before falling.
    rst                    = 1'b1;
    bus.io_uart_txd        = 2'b11;
    bus.io_cfg_loopback    = 2'b00;
    bus.io_cfg_rx_pue      = 2'b10;
    bus.io_cfg_filt_len    = 4'd2;
    bus.io_pins_rxd_i_ival = 2'b00;
    bus.io_pins_txd_i_ival = 2'b00;
    step(2);
    chk("rst_pue_passthru", bus.io_pins_rxd_o_pue, 2'b10);
    chk("rst_const_pads", const_pads(), 16'h0CC0);
    rst = 1'b0;
    chk("rst_rxd_idle", bus.io_uart_rxd, 2'b11);
    meas(0, 1'b0, lat);
    chk("rst_release_lat", lat, exp_lat(2));
    chk("rst_release_rxd", bus.io_uart_rxd, 2'b00);

    // Steady-state table with L=2.
    bus.io_cfg_filt_len = 4'd2;
    for (int v = 0; v < 6; v++) begin
      bus.io_cfg_loopback    = vt[v].loop;
      bus.io_uart_txd        = vt[v].txd;
      bus.io_cfg_rx_pue      = vt[v].pue;
      bus.io_pins_rxd_i_ival = vt[v].pad;
      step(20);
      chk($sformatf("vec%0d_txd_oval", v), bus.io_pins_txd_o_oval, vt[v].e_oval);
      chk($sformatf("vec%0d_rx_pue", v), bus.io_pins_rxd_o_pue, vt[v].e_pue);
      chk($sformatf("vec%0d_rxd", v), bus.io_uart_rxd, vt[v].e_rxd);
      chk($sformatf("vec%0d_const_pads", v), const_pads(), 16'h0CC0);
    end

    // Latency for L=4 and L=0.
    settle(4'd4);
    bus.io_pins_rxd_i_ival[0] = 1'b0;
    meas(0, 1'b0, lat);
    chk("lat_L4", lat, exp_lat(4));
    settle(4'd0);
    bus.io_pins_rxd_i_ival[0] = 1'b0;
    meas(0, 1'b0, lat);
    chk("lat_L0", lat, exp_lat(0));

    // Glitches of 1, 4 and 5 cycles with L=4.
    glen[0] = 1; glen[1] = 4; glen[2] = 5;
    for (int g = 0; g < 3; g++) begin
      settle(4'd4);
      seen = 1'b0;
      bus.io_pins_rxd_i_ival[0] = 1'b0;
      for (int k = 1; k <= 30; k++) begin
        @(posedge clk);
        #1;
        if (bus.io_uart_rxd[0] == 1'b0) seen = 1'b1;
        if (k == glen[g]) bus.io_pins_rxd_i_ival[0] = 1'b1;
      end
      chk($sformatf("glitch_len%0d_seen_low", glen[g]), seen, (FILT ? (glen[g] >= 5) : 1));
    end

    // Loopback on channel 1 only.
    settle(4'd2);
    bus.io_cfg_loopback = 2'b10;
    bus.io_uart_txd[1]  = 1'b0;
    #1;
    chk("loop_txd_oval_idle", bus.io_pins_txd_o_oval, 2'b11);
    meas(1, 1'b0, lat);
    chk("loop_fall_lat", lat, exp_lat(2));
    chk("loop_ch0_hold", bus.io_uart_rxd[0], 1);
    bus.io_uart_txd[0] = 1'b0;
    bus.io_uart_txd[1] = 1'b1;
    #1;
    chk("loop_txd_oval_ch0", bus.io_pins_txd_o_oval, 2'b10);
    meas(1, 1'b1, lat);
    chk("loop_rise_lat", lat, exp_lat(2));
    step(5);
    chk("loop_ch0_still", bus.io_uart_rxd[0], 1);

    // Live filter-length change: L=15, count reaches 6, then L=3 releases on the next edge.
    settle(4'd15);
    bus.io_pins_rxd_i_ival[0] = 1'b0;
    step(8);
    chk("liveL_hold", bus.io_uart_rxd[0], (FILT ? 1 : 0));
    bus.io_cfg_filt_len = 4'd3;
    step(1);
    chk("liveL_update", bus.io_uart_rxd[0], 0);

    // Reset mid-filter abandons the pending transition.
    settle(4'd4);
    bus.io_pins_rxd_i_ival[0] = 1'b0;
    step(5);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("midrst_idle", bus.io_uart_rxd, 2'b11);
    meas(0, 1'b0, lat);
    chk("midrst_restart_lat", lat, exp_lat(4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sirv_uartgpioport_mc.md
SIRV_UARTGPIOPORT_MC -- requirements
Module: sirv_uartgpioport_mc

Interface
REQ-001 Parameter NCH, default 1: number of independent UART pin channels (1..8).
REQ-002 Parameter FILT_W, default 4: width of each RX glitch-filter length/counter.
REQ-003 clock  input  1  single block clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 io_uart_txd  input  NCH  per-channel TX data from the UART cores.
REQ-006 io_uart_rxd  output  NCH  per-channel synchronised, filtered RX data to the UART cores.
REQ-007 io_cfg_filt_len  input  FILT_W  glitch-filter length L, shared by all channels.
REQ-008 io_cfg_loopback  input  NCH  per-channel internal loopback enable.
REQ-009 io_cfg_rx_pue  input  NCH  per-channel RX pad pull-up enable request.
REQ-010 io_pins_rxd_i_ival  input  NCH  RX pad input values (asynchronous).
REQ-011 io_pins_rxd_o_oval/oe/ie/pue/ds  output  NCH each  RX pad controls.
REQ-012 io_pins_txd_i_ival  input  NCH  TX pad input values (unused).
REQ-013 io_pins_txd_o_oval/oe/ie/pue/ds  output  NCH each  TX pad controls.

Function
REQ-014 Bit i of every vector SHALL belong to channel i; channels SHALL be fully independent except for the shared io_cfg_filt_len.
REQ-015 RX pad controls SHALL be constant: oval=0, oe=0, ie=1, ds=0; pue SHALL equal io_cfg_rx_pue combinationally.
REQ-016 TX pad controls: oe=1, ie=0, pue=0, ds=0; oval SHALL equal io_uart_txd, except that it SHALL be 1 (idle) while io_cfg_loopback is set.
REQ-017 Source mux per channel: src = io_cfg_loopback ? io_uart_txd : io_pins_rxd_i_ival.
REQ-018 src SHALL pass through a two-flop synchroniser (s1, s2), giving 2 cycles of latency.
REQ-019 Filter state per channel: registered output f and counter cnt (FILT_W bits); io_uart_rxd = f.
REQ-020 If s2 == f, cnt SHALL be cleared to 0 on the next edge.
REQ-021 If s2 != f and cnt >= L, f SHALL load s2 and cnt SHALL clear on the same edge.
REQ-022 If s2 != f and cnt < L, cnt SHALL increment by 1 and f SHALL hold; cnt SHALL never wrap, because the >= test fires first.
REQ-023 Latency from a stable src change to io_uart_rxd SHALL be exactly L+3 cycles; any src pulse shorter than L+1 cycles at s2 SHALL be suppressed.
REQ-024 L=0 SHALL give no filtering, and the total latency SHALL be 3 cycles.
REQ-025 A change to io_cfg_filt_len SHALL take effect on the next compare; if cnt already >= the new L while s2 != f, f SHALL update on the next edge.
REQ-026 A change to io_cfg_loopback SHALL only switch src; the synchroniser and filter SHALL filter the switch glitch like any other input.

Reset
REQ-027 When reset is high at a clock edge, s1, s2 and f SHALL be set to 1 and cnt to 0, for all channels.
REQ-028 Immediately after reset, io_uart_rxd SHALL be all ones (line idle); combinational pad outputs SHALL be unaffected by reset.
REQ-029 Reset asserted mid-filter SHALL abandon any pending transition; counting SHALL restart from 0.

Configuration
REQ-030 Macro SIRV_UARTGPIOPORT_MC_FILTER_EN: when defined, the glitch filter SHALL be built as in REQ-019..025.
REQ-031 When SIRV_UARTGPIOPORT_MC_FILTER_EN is undefined, no cnt or f registers SHALL exist, io_uart_rxd SHALL equal s2 (latency 2), and io_cfg_filt_len SHALL be ignored.

Verification
REQ-032 Reset: NCH=2, hold reset 2 cycles, pads=0 -> io_uart_rxd=2'b11 in the first cycle after reset; pads then reach rxd 0 at cycle L+3.
REQ-033 Latency: L=4, rxd pad 1->0 held -> io_uart_rxd falls exactly 7 cycles later; with L=0 -> it falls 3 cycles later.
REQ-034 Glitch: L=4, pad low for 4 cycles then high -> io_uart_rxd stays 1; pad low for 5 cycles -> io_uart_rxd pulses low.
REQ-035 Loopback: ch1 loopback=1, io_uart_txd[1] toggles -> txd_o_oval[1]=1 and io_uart_rxd[1] follows txd after L+3 cycles; ch0 is unaffected.
REQ-036 Live L change: L=15, mismatch held with cnt=6, then set L=3 -> f updates on the next edge.
REQ-037 Filter compiled out: any L, pad 1->0 -> io_uart_rxd falls after 2 cycles, and 1-cycle glitches pass through.
